// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multicycle MIPS-style control unit:
// state encoding, opcodes, datapath mux encodings and the control bundle.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Everything the state table drives; pc_write and branch stay internal.
  typedef struct packed {
    logic   iord;
    logic   mem_write;
    logic   ir_write;
    logic   reg_dst;
    logic   memto_reg;
    logic   reg_write;
    logic   alu_src_a;
    srcb_t  alu_src_b;
    pcsrc_t pc_src;
    aluop_t alu_op;
    logic   pc_write;
    logic   branch;
    logic   illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/flag inputs from the datapath and the
// control strobes back to it. master = datapath side, slave = control unit.
interface multicycle_control_unit_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] Opcode;
  logic            Zero;
  logic            IorD;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegDst;
  logic            MemtoReg;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSrc;
  logic [1:0]      ALUOp;
  logic            PCEn;
  logic            IllegalOp;
  logic [ST_W-1:0] State;

  modport master (
    output Opcode, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUOp, PCEn, IllegalOp, State
  );

  modport slave (
    input  Opcode, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUOp, PCEn, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// Combinational state-to-control table. Outputs depend on the state only,
// except IllegalOp in DECODE, which also looks at the opcode. While reset is
// held the write strobes are suppressed so nothing in the datapath changes.
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       reset,
  output ctrl_t      ctrl
);

  // Per-state control table, then the reset write-suppression override.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case can infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: ctrl.iord = 1'b1;
      S_MEMWRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;  // unused codes 12-15: everything stays 0
    endcase
    if (reset) begin
      ctrl.ir_write  = 1'b0;
      ctrl.pc_write  = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: Moore FSM sequencing FETCH/DECODE and the
// per-instruction execute states. Next-state logic and the state register
// live here; the control table is in mcu_output_decode.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.slave  bus
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] opcode;
  ctrl_t      ctrl;

  assign opcode = 6'(bus.Opcode);

  // State register; reset drops straight to FETCH without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state: opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;  // terminal states and unused codes
    endcase
  end

  mcu_output_decode u_output_decode (
    .state  (state_q),
    .opcode (opcode),
    .reset  (reset),
    .ctrl   (ctrl)
  );

  // Drive the bus; PCEn is the only output that looks at Zero.
  always_comb begin
    bus.IorD      = ctrl.iord;
    bus.MemWrite  = ctrl.mem_write;
    bus.IRWrite   = ctrl.ir_write;
    bus.RegDst    = ctrl.reg_dst;
    bus.MemtoReg  = ctrl.memto_reg;
    bus.RegWrite  = ctrl.reg_write;
    bus.ALUSrcA   = ctrl.alu_src_a;
    bus.ALUSrcB   = ctrl.alu_src_b;
    bus.PCSrc     = ctrl.pc_src;
    bus.ALUOp     = ctrl.alu_op;
    bus.PCEn      = ctrl.pc_write | (ctrl.branch & bus.Zero);
    bus.IllegalOp = ctrl.illegal_op;
    bus.State     = ST_W'(state_q);
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each instruction pushes its expected per-cycle state
// sequence; the drain loop drives Opcode/Zero for that cycle and compares the
// DUT against a reference table of the control outputs.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OP_W(6), .ST_W(4)) bus ();

  multicycle_control_unit #(.OP_W(6), .ST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUOp,PCEn,IllegalOp,State}
  localparam logic [18:0] RST_VEC = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] dut_vec();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUOp,
            bus.PCEn, bus.IllegalOp, bus.State};
  endfunction

  // Reference control table written straight from the state descriptions.
  function automatic logic [18:0] model(input logic [3:0] st, input logic [5:0] op, input logic z);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
    logic [1:0] srcb, pcs, aop;
    {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin irw = 1; srcb = 2'b01; pcen = 1; end
      4'd1:  begin srcb = 2'b11;
                   ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b001000, 6'b000010}); end
      4'd2:  begin sa = 1; srcb = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iord = 1; mw = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      4'd9:  begin sa = 1; srcb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, srcb, pcs, aop, pcen, ill, st};
  endfunction

  // Push the expected state sequence for one instruction.
  task automatic push_instr(input logic [5:0] op, input logic z);
    logic [3:0] seq[$];
    case (op)
      6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
      6'b000100: seq = '{4'd0, 4'd1, 4'd8};
      6'b000010: seq = '{4'd0, 4'd1, 4'd11};
      default:   seq = '{4'd0, 4'd1};
    endcase
    foreach (seq[i]) sb.push_back('{st: seq[i], op: op, zero: z});
  endtask

  // Pop up to n entries, one per cycle; Opcode is garbage outside DECODE/MEMADR
  // and Zero is garbage outside BRANCH, neither of which may matter.
  task automatic drain_n(input int n);
    exp_t       e;
    logic [5:0] drv_op;
    logic       drv_z;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      e = sb.pop_front();
      @(negedge clk);
      drv_op = (e.st == 4'd1 || e.st == 4'd2) ? e.op : 6'($urandom);
      drv_z  = (e.st == 4'd8) ? e.zero : 1'($urandom);
      bus.Opcode = drv_op;
      bus.Zero   = drv_z;
      #1;
      check($sformatf("state op=%b", e.op), 32'(bus.State), 32'(e.st));
      check($sformatf("ctrl st=%0d op=%b", e.st, e.op), 32'(dut_vec()),
            32'(model(e.st, drv_op, drv_z)));
    end
  endtask

  task automatic drain();
    drain_n(1000);
  endtask

  initial begin
    reset      = 1'b1;
    bus.Opcode = 6'b111111;
    bus.Zero   = 1'b1;
    #2;
    check("reset_vec", 32'(dut_vec()), 32'(RST_VEC));
    @(posedge clk); #1;
    check("reset_hold", 32'(dut_vec()), 32'(RST_VEC));
    reset = 1'b0;

    push_instr(6'b100011, 1'b0); drain();             // LW
    push_instr(6'b101011, 1'b0); drain();             // SW
    push_instr(6'b000000, 1'b0);                      // RTYPE then ADDI back to back
    push_instr(6'b001000, 1'b0); drain();
    push_instr(6'b000100, 1'b1); drain();             // BEQ taken
    push_instr(6'b000100, 1'b0); drain();             // BEQ not taken
    push_instr(6'b000010, 1'b0); drain();             // J
    push_instr(6'b111111, 1'b0); drain();             // illegal
    push_instr(6'b000001, 1'b0); drain();             // illegal
    push_instr(6'b000000, 1'b1); drain();             // RTYPE

    // Reset pulse in MEMREAD: state must drop to FETCH before any clk edge.
    push_instr(6'b100011, 1'b0);
    drain_n(4);
    #1 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.State), 32'd0);
    check("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("async_rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("async_rst_vec", 32'(dut_vec()), 32'(RST_VEC));
    @(posedge clk); #1;
    check("rst_after_edge", 32'(dut_vec()), 32'(RST_VEC));
    reset = 1'b0;
    sb.delete();

    push_instr(6'b101011, 1'b0); drain();             // SW after reset
    push_instr(6'b100011, 1'b0); drain();             // LW after reset

    @(negedge clk); #1;
    check("final_fetch", 32'(bus.State), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: OP_W, 6, opcode field width.
REQ-002 Parameter: ST_W, 4, state register width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Opcode  input  OP_W  instruction bits [31:26] from instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath mux selects and write enables.
REQ-008 ALUSrcB  output  2  ALU B mux select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-009 PCSrc  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 ALUOp  output  2  00 add, 01 subtract, 10 decode by funct.
REQ-011 PCEn  output  1  PC register enable.
REQ-012 IllegalOp  output  1  unknown opcode seen in DECODE.
REQ-013 State  output  ST_W  current state, debug.

Function
REQ-014 Moore FSM; all outputs except PCEn are decoded from the state register only; PCEn = PCWrite | (Branch & Zero), where PCWrite and Branch are internal state-decoded signals.
REQ-015 Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-016 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 go to FETCH next cycle with all outputs 0.
REQ-017 Transitions: FETCH->DECODE; DECODE->MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEXEC (ADDI), JUMP (J), FETCH (other).
REQ-018 Transitions: MEMADR->MEMREAD (LW) or MEMWRITE (SW), using Opcode sampled in MEMADR; MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-019 Signals not listed for a state are 0 in that state.
REQ-020 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
REQ-021 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; IllegalOp=1 only if Opcode is not in REQ-015.
REQ-022 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-023 MEMREAD: IorD=1; MEMWRITE: IorD=1, MemWrite=1.
REQ-024 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-025 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
REQ-027 JUMP: PCSrc=10, PCWrite=1.
REQ-028 Instruction latency in cycles: LW 5; SW, RTYPE, ADDI 4; BEQ, J 3; illegal 2.
REQ-029 Opcode changing outside DECODE/MEMADR has no effect on state.

Reset
REQ-030 reset=1 forces the state to FETCH immediately, without waiting for clk, including mid-instruction.
REQ-031 While reset=1, outputs equal FETCH decode with PCWrite, IRWrite, RegWrite and MemWrite forced to 0; State=0.
REQ-032 First rising edge after reset deasserts executes FETCH.

Structure
REQ-033 Shared package holds the state enumeration, opcode constants, and ALUSrcB, PCSrc and ALUOp encodings.
REQ-034 One sub-module: mcu_output_decode, a combinational state-to-control table; the next-state logic and state register stay in the top.

Verification
REQ-035 Reset pulse during MEMREAD -> State=0 with no clk edge; MemWrite=0 and RegWrite=0 during reset.
REQ-036 LW (100011) -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-037 SW (101011) -> sequence 0,1,2,5,0; MemWrite=1 and IorD=1 only in state 5; RegWrite never 1.
REQ-038 BEQ with Zero=1 -> PCEn=1 in BRANCH; with Zero=0 -> PCEn=0 in BRANCH; PCSrc=01 in both cases.
REQ-039 Opcode 111111 -> IllegalOp=1 in DECODE, then FETCH; J (000010) -> PCSrc=10 and PCEn=1 in JUMP.
REQ-040 Back-to-back RTYPE then ADDI -> sequences 0,1,6,7 then 0,1,9,10; ALUOp=10 only in state 6.
